frame_read_controller: RTL and testbench
========================================

# frame_read_controller

Parametrised frame-memory read controller and pixel serialiser. It sits between the frame buffer RAM and the display timing path. It tracks externally supplied vsync/hsync plus porch/resolution settings, fetches packed words (PIX_PER_WORD pixels each) from one of two ping-pong frame banks, and emits one pixel per clock with a data-enable and start-of-frame marker.

## Interface
- PIX_WIDTH, 24: bits per pixel
- PIX_PER_WORD, 4: pixels packed per memory word; ≥1
- DATA_WIDTH, PIX_WIDTH*PIX_PER_WORD: memory word width
- FRAME_WORDS, 512*512/4: words reserved per frame bank
- ADDR_DEPTH, 2*FRAME_WORDS: total memory words (two banks)
- ADDR_WIDTH, $clog2(ADDR_DEPTH): address width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_vsync  in  1  vertical sync, level; rising edge starts frame
- i_hsync  in  1  horizontal sync, level; rising edge starts line
- i_vbp  in  10  lines skipped after vsync edge before first active line
- i_hbp  in  10  cycles skipped after hsync edge before first active pixel
- i_vres  in  11  active lines per frame
- i_hres  in  11  active pixels per line
- i_bank_sel  in  1  bank to read next frame, sampled at vsync edge
- o_ren  out  1  memory read enable
- o_raddr  out  ADDR_WIDTH  memory read address
- i_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after o_ren
- o_pix  out  PIX_WIDTH  output pixel
- o_de  out  1  o_pix valid
- o_sof  out  1  one-cycle pulse with first pixel of frame

## Operation
- Edge detect: register previous i_vsync/i_hsync; edge cycle E = input 1, previous 0.
- FSM states: IDLE, VBLANK, HBP, ACTIVE, HWAIT.
  - IDLE -> VBLANK on vsync edge.
  - vsync edge in any state: latch bank, clear line counter, set address to bank base (0 or FRAME_WORDS), enter VBLANK; this aborts any frame in progress, since vsync has priority.
  - VBLANK/HWAIT: each hsync edge increments line index L (first hsync after vsync is L=0).
    - L in [vbp, vbp+vres-1] -> HBP.
    - Else stay.
    - After line vbp+vres-1 completes -> IDLE.
  - HBP: count i_hbp cycles after E, then ACTIVE. i_hbp=0 -> ACTIVE on cycle E+1.
  - ACTIVE: pixel counter k = 0..i_hres-1, one per cycle, then HWAIT. An hsync edge during HBP/ACTIVE aborts the current line and is counted as the next line.
- Fetch:
  - o_ren=1 in ACTIVE cycles where k mod PIX_PER_WORD == 0.
  - o_raddr is the current word address.
  - Address increments after each read and wraps modulo ADDR_DEPTH.
  - Address is a running counter across lines, so ceil(hres/PIX_PER_WORD) words are consumed per line.
  - Partially used last words are discarded; the next line starts on a fresh word.
- Unpack: pixel j of word = i_rdata[j*PIX_WIDTH +: PIX_WIDTH], j=0 first (LSB first). The word is held in a register while its remaining pixels shift out.
- Zero-size cases:
  - i_vres=0 or i_hres=0: no reads and no o_de for the frame.
  - Sync/porch/resolution inputs other than i_bank_sel are sampled live and must be static within a frame.
- Reset values:
  - All outputs 0.
  - FSM in IDLE, counters 0, bank latch 0.
  - Sync history registers 0, so a high sync at reset release counts as an edge.
  - Reset mid-frame discards everything; no output until the next vsync edge.

## Timing
- Active pixel k of a line occurs at cycle T0+k, where T0 = E+1+i_hbp.
- o_ren for word w at cycle T0+w*PIX_PER_WORD; data returns the following cycle.
- Output latency is 2 cycles: o_de=1 and o_pix = pixel k at cycle T0+k+2, for i_hres consecutive cycles.
- o_sof is high together with the first o_de of line L=vbp.
- An aborted line drops o_de 2 cycles after the aborting edge, including pixels still in the pipeline. The same rule applies to vsync aborts.
- Back-to-back lines: with hsync period ≥ 1+i_hbp+i_hres+2, no pixel is lost.

## Test plan
- PIX_PER_WORD=4, vbp=2, vres=3, hbp=5, hres=8, bank_sel=0, word at addr a = {4 pixels a*4+3..a*4} -> reads addr 0..5 at T0, T0+4 per line; o_pix 0..23 sequential; o_sof once; 24 o_de cycles total.
- Same with bank_sel=1 -> first o_raddr = FRAME_WORDS. Toggle bank_sel mid-frame -> no effect until the next vsync.
- hres=6, PIX_PER_WORD=4 -> 2 reads per line; line 1 starts at addr 2; pixels 6,7 of word 1 never output.
- hsync edge at k=3 of an 8-pixel line -> o_de drops 2 cycles later; next line starts at address one past the last word read; line count advances.
- vsync mid-frame and rst_n low mid-line -> o_de/o_ren drop (immediately for reset); address restarts at bank base on the next frame.
- hres=0 or vres=0 -> o_ren and o_de stay 0 across the full frame; FSM returns to IDLE.

Source files
------------

// File: rtl/frame_read_controller.sv
// Frame-memory read controller: tracks vsync/hsync with porches, fetches packed
// words from one of two ping-pong banks and serialises one pixel per clock.
module frame_read_controller #(
  parameter int PIX_WIDTH    = 24,
  parameter int PIX_PER_WORD = 4,
  parameter int DATA_WIDTH   = PIX_WIDTH * PIX_PER_WORD,
  parameter int FRAME_WORDS  = 512 * 512 / 4,
  parameter int ADDR_DEPTH   = 2 * FRAME_WORDS,
  parameter int ADDR_WIDTH   = $clog2(ADDR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vsync,
  input  logic                  i_hsync,
  input  logic [9:0]            i_vbp,
  input  logic [9:0]            i_hbp,
  input  logic [10:0]           i_vres,
  input  logic [10:0]           i_hres,
  input  logic                  i_bank_sel,
  output logic                  o_ren,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [PIX_WIDTH-1:0]  o_pix,
  output logic                  o_de,
  output logic                  o_sof
);

  // state  | meaning
  // IDLE   | no frame in progress, waiting for a vsync edge
  // VBLANK | counting lines of the vertical back porch
  // HBP    | counting horizontal back-porch cycles of an active line
  // ACTIVE | issuing pixels of an active line
  // HWAIT  | active line finished, waiting for the next hsync edge
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VBLANK = 3'd1;
  localparam logic [2:0] HBP    = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] HWAIT  = 3'd4;

  localparam int PH_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [PH_W-1:0]       PH_LAST    = PH_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(ADDR_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(FRAME_WORDS);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

  logic                  vs_q, hs_q;
  logic                  vs_edge, hs_edge, any_edge;
  logic [2:0]            state, state_nx;
  logic                  bank_q;
  logic [11:0]           line_cnt, cur_line;
  logic [11:0]           first_line, end_line, last_line;
  logic                  in_range, line_done, act;
  logic [9:0]            hbp_cnt;
  logic [10:0]           pix_cnt;
  logic [PH_W-1:0]       ph;
  logic [ADDR_WIDTH-1:0] word_cnt, bank_base;
  logic [ADDR_WIDTH:0]   raddr_sum;

  logic                  s1_vld, s1_sof;
  logic [PH_W-1:0]       s1_ph;
  logic [DATA_WIDTH-1:0] word_q, cur_word;
  logic [PIX_WIDTH-1:0]  pix_sel;

  assign vs_edge  = i_vsync & ~vs_q;
  assign hs_edge  = i_hsync & ~hs_q;
  assign any_edge = vs_edge | hs_edge;

  assign first_line = {2'b00, i_vbp};
  assign end_line   = first_line + {1'b0, i_vres};
  assign last_line  = end_line - 12'd1;
  assign in_range   = (line_cnt >= first_line) && (line_cnt < end_line);
  assign line_done  = (i_hres == 11'd0) || (pix_cnt == i_hres - 11'd1);

  // A sync edge kills the pixel slot it lands on, so o_de falls two cycles later.
  assign act   = (state == ACTIVE) && (i_hres != 11'd0) && !any_edge;
  assign o_ren = act && (ph == '0);

  assign bank_base = bank_q ? BANK1_BASE : '0;
  assign raddr_sum = {1'b0, word_cnt} + {1'b0, bank_base};
  assign o_raddr   = (raddr_sum >= DEPTH_EXT) ? ADDR_WIDTH'(raddr_sum - DEPTH_EXT)
                                              : raddr_sum[ADDR_WIDTH-1:0];

  always_comb begin
    state_nx = state;
    if (vs_edge) begin
      state_nx = VBLANK;
    end else if (state != IDLE && hs_edge) begin
      if (in_range)
        state_nx = (i_hbp == 10'd0) ? ACTIVE : HBP;
      else if (line_cnt >= end_line)
        state_nx = IDLE;
      else
        state_nx = VBLANK;
    end else begin
      case (state)
        HBP:     if (hbp_cnt <= 10'd1) state_nx = ACTIVE;
        ACTIVE:  if (line_done) state_nx = (cur_line == last_line) ? IDLE : HWAIT;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      state    <= IDLE;
      bank_q   <= 1'b0;
      line_cnt <= '0;
      cur_line <= '0;
      hbp_cnt  <= '0;
      pix_cnt  <= '0;
      ph       <= '0;
      word_cnt <= '0;
    end else begin
      vs_q  <= i_vsync;
      hs_q  <= i_hsync;
      state <= state_nx;

      if (vs_edge) begin
        bank_q   <= i_bank_sel;
        line_cnt <= '0;
        word_cnt <= '0;
      end else begin
        if (state != IDLE && hs_edge) begin
          cur_line <= line_cnt;
          line_cnt <= line_cnt + 12'd1;
        end
        if (o_ren)
          word_cnt <= (word_cnt == ADDR_LAST) ? '0 : word_cnt + 1'b1;
      end

      if (hs_edge)
        hbp_cnt <= i_hbp;
      else if (state == HBP)
        hbp_cnt <= hbp_cnt - 10'd1;

      if (act) begin
        pix_cnt <= pix_cnt + 11'd1;
        ph      <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      end else begin
        pix_cnt <= '0;
        ph      <= '0;
      end
    end
  end

  // Read data arrives with phase 0; later phases come from the held word.
  assign cur_word = (s1_ph == '0) ? i_rdata : word_q;

  always_comb begin
    pix_sel = '0;
    for (int j = 0; j < PIX_PER_WORD; j++)
      if (s1_ph == PH_W'(j)) pix_sel = cur_word[j*PIX_WIDTH +: PIX_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_sof <= 1'b0;
      s1_ph  <= '0;
      word_q <= '0;
      o_de   <= 1'b0;
      o_sof  <= 1'b0;
      o_pix  <= '0;
    end else begin
      s1_vld <= act;
      s1_sof <= act && (pix_cnt == 11'd0) && (cur_line == first_line);
      s1_ph  <= ph;
      if (s1_vld && s1_ph == '0)
        word_q <= i_rdata;
      o_de  <= s1_vld;
      o_sof <= s1_vld && s1_sof;
      o_pix <= s1_vld ? pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_frame_read_controller.sv
// Scoreboard bench for frame_read_controller: a line/word model queues the
// expected read addresses and pixels, and a monitor checks them as they appear.
module tb_frame_read_controller;

  localparam int PW  = 24;
  localparam int PPW = 4;
  localparam int DW  = PW * PPW;
  localparam int FW  = 512 * 512 / 4;
  localparam int AW  = $clog2(2 * FW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_vsync, i_hsync, i_bank_sel;
  logic [9:0]    i_vbp, i_hbp;
  logic [10:0]   i_vres, i_hres;
  logic          o_ren;
  logic [AW-1:0] o_raddr;
  logic [DW-1:0] i_rdata;
  logic [PW-1:0] o_pix;
  logic          o_de, o_sof;

  int total = 0;
  int bad   = 0;
  bit ignore_mon = 1'b1;

  int exp_addr_q[$];
  int exp_pix_q[$];
  bit exp_sof_q[$];

  frame_read_controller dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_vbp(i_vbp), .i_hbp(i_hbp), .i_vres(i_vres), .i_hres(i_hres),
    .i_bank_sel(i_bank_sel), .o_ren(o_ren), .o_raddr(o_raddr),
    .i_rdata(i_rdata), .o_pix(o_pix), .o_de(o_de), .o_sof(o_sof)
  );

  always #5 clk = ~clk;

  // Word at address a carries pixels a*4 .. a*4+3, LSB first.
  function automatic logic [DW-1:0] mk_word(int a);
    logic [DW-1:0] w;
    for (int j = 0; j < PPW; j++) w[j*PW +: PW] = PW'(a * PPW + j);
    return w;
  endfunction

  always @(posedge clk) if (o_ren) i_rdata <= mk_word(int'(o_raddr));

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(string name, longint act);
    total++;
    bad++;
    $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && !ignore_mon) begin
      if (o_ren) begin
        if (exp_addr_q.size() == 0) unexpected("raddr_extra", o_raddr);
        else chk("raddr", o_raddr, exp_addr_q.pop_front());
      end
      if (o_de) begin
        if (exp_pix_q.size() == 0) unexpected("pix_extra", o_pix);
        else begin
          chk("pix", o_pix, exp_pix_q.pop_front());
          chk("sof", o_sof, exp_sof_q.pop_front());
        end
      end else if (o_sof) begin
        unexpected("sof_without_de", o_sof);
      end
    end
  end

  // Lines are hsync edges 'per' cycles apart; the event after the last line
  // (next vsync) also arrives 'per' cycles later, so every active line yields
  // min(hres, per-1-hbp) pixels.
  task automatic run_frame(int vbp, int vres, int hbp, int hres, int bank, int per, int nhs);
    int a, issued;
    a = bank ? FW : 0;
    for (int l = 0; l < nhs; l++) begin
      if (l >= vbp && l < vbp + vres) begin
        issued = per - 1 - hbp;
        if (issued < 0) issued = 0;
        if (issued > hres) issued = hres;
        for (int k = 0; k < issued; k++) begin
          if (k % PPW == 0) exp_addr_q.push_back(a + k / PPW);
          exp_pix_q.push_back((a + k / PPW) * PPW + k % PPW);
          exp_sof_q.push_back((k == 0) && (l == vbp));
        end
        a += (issued + PPW - 1) / PPW;
      end
    end
    @(posedge clk); #1;
    i_vbp = 10'(vbp); i_hbp = 10'(hbp); i_vres = 11'(vres); i_hres = 11'(hres);
    i_bank_sel = 1'(bank);
    i_vsync = 1'b1;
    @(posedge clk); #1;
    i_vsync = 1'b0;
    i_bank_sel = ~1'(bank);
    repeat (2) @(posedge clk);
    for (int n = 0; n < nhs; n++) begin
      @(posedge clk); #1 i_hsync = 1'b1;
      @(posedge clk); #1 i_hsync = 1'b0;
      repeat (per - 2) @(posedge clk);
    end
  endtask

  task automatic drain_and_check(string name);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk({name, "_addr_left"}, exp_addr_q.size(), 0);
    chk({name, "_pix_left"}, exp_pix_q.size(), 0);
    chk({name, "_state_idle"}, dut.state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    i_vsync = 1'b0; i_hsync = 1'b0; i_bank_sel = 1'b0;
    i_vbp = '0; i_hbp = '0; i_vres = '0; i_hres = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ren", o_ren, 0);
    chk("rst_raddr", o_raddr, 0);
    chk("rst_de", o_de, 0);
    chk("rst_sof", o_sof, 0);
    chk("rst_pix", o_pix, 0);
    chk("rst_state", dut.state, 0);
    ignore_mon = 1'b0;

    run_frame(2, 3, 5, 8, 0, 20, 5);   // bank 0, pixels 0..23
    run_frame(2, 3, 5, 8, 1, 20, 5);   // bank 1, starts at FRAME_WORDS
    run_frame(0, 2, 3, 6, 0, 20, 2);   // hres=6: two words per line
    run_frame(0, 3, 5, 8, 0, 9, 3);    // each line cut by hsync at k=3
    run_frame(1, 3, 2, 8, 0, 7, 2);    // line 1 cut by vsync at k=4
    run_frame(0, 2, 1, 8, 1, 20, 2);
    drain_and_check("main");

    run_frame(1, 2, 2, 0, 0, 10, 4);   // hres=0
    drain_and_check("hres0");
    run_frame(2, 0, 2, 8, 0, 10, 4);   // vres=0
    drain_and_check("vres0");

    // Reset in the middle of an active line.
    ignore_mon = 1'b1;
    @(posedge clk); #1;
    i_vbp = 10'd0; i_hbp = 10'd1; i_vres = 11'd2; i_hres = 11'd8; i_bank_sel = 1'b1;
    i_vsync = 1'b1;
    @(posedge clk); #1 i_vsync = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 i_hsync = 1'b1;
    @(posedge clk); #1 i_hsync = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = o_de;
    end
    chk("midline_de_seen", seen, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_de", o_de, 0);
    chk("rst_mid_ren", o_ren, 0);
    chk("rst_mid_sof", o_sof, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_de", o_de, 0);
    chk("post_rst_ren", o_ren, 0);
    exp_addr_q.delete();
    exp_pix_q.delete();
    exp_sof_q.delete();
    ignore_mon = 1'b0;

    run_frame(0, 2, 1, 8, 0, 20, 2);   // restarts at bank 0 base
    drain_and_check("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
